// File: rtl/cpu_fmt_pkg.sv
// Shared constants, encodings and helpers for the CPU trace-line formatter.
// Characters, record kinds, FSM states and the double-dabble step live here.
package cpu_fmt_pkg;

    localparam logic [7:0] ASC_CARET  = 8'h5E;
    localparam logic [7:0] ASC_AT     = 8'h40;
    localparam logic [7:0] ASC_COLON  = 8'h3A;
    localparam logic [7:0] ASC_SPACE  = 8'h20;
    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_STAR   = 8'h2A;
    localparam logic [7:0] ASC_LT     = 8'h3C;
    localparam logic [7:0] ASC_EQ     = 8'h3D;
    localparam logic [7:0] ASC_HASH   = 8'h23;

    localparam int unsigned CONV_CYCLES = 14;
    localparam logic [13:0] TIME_MAX    = 14'd9999;

    typedef enum logic {
        KIND_REG = 1'b0,
        KIND_MEM = 1'b1
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h57 + {4'h0, nib};
        end
    endfunction

    function automatic logic [3:0] nib_of(input logic [31:0] word, input logic [2:0] idx);
        return word[4*idx +: 4];
    endfunction

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next bit.
    function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic bit_in);
        logic [15:0] adj;
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return {adj[14:0], bit_in};
    endfunction

endpackage

// File: rtl/cpu_fmt_bcd.sv
// Iterative 14-bit binary to 4-digit BCD converter, one bit per cycle.
// The start edge already consumes the MSB, so done pulses after 14 edges total.
module cpu_fmt_bcd
    import cpu_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [13:0] bin_i,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    logic [13:0] sh_q;
    logic [15:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        done_q;

    // Shift/add-3 datapath with a remaining-step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= 14'd0;
            bcd_q  <= 16'd0;
            cnt_q  <= 4'd0;
            done_q <= 1'b0;
        end else if (start_i) begin
            sh_q   <= {bin_i[12:0], 1'b0};
            bcd_q  <= {15'd0, bin_i[13]};
            cnt_q  <= 4'(CONV_CYCLES - 1);
            done_q <= 1'b0;
        end else if (cnt_q != 4'd0) begin
            sh_q   <= {sh_q[12:0], 1'b0};
            bcd_q  <= dd_step(bcd_q, sh_q[13]);
            cnt_q  <= cnt_q - 4'd1;
            done_q <= (cnt_q == 4'd1);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/cpu_formatter.sv
// Formats register/memory write records into ASCII trace lines, one character
// per handshake, after converting the timestamp to decimal.
module cpu_formatter
    import cpu_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_kind,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  out_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done
);

    state_e      state_q;
    kind_e       kind_q;
    logic [31:0] pc_q;
    logic [4:0]  reg_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [5:0]  idx_q;
    logic [7:0]  char_q;
    logic        valid_q;

    logic        accept_s;
    logic [13:0] time_sat_s;
    logic        bcd_done_s;
    logic [15:0] bcd_s;

    logic [5:0]  tlen_s;
    logic [5:0]  rlen_s;
    logic [5:0]  vlen_s;
    logic [3:0]  reg_tens_s;
    logic [3:0]  reg_ones_s;
    logic [5:0]  k_s;
    logic [5:0]  j_s;
    logic [5:0]  m_s;
    logic [5:0]  n_s;
    logic [7:0]  next_char_d;

    assign in_ready   = (state_q == ST_IDLE);
    assign accept_s   = in_valid && (state_q == ST_IDLE);
    assign time_sat_s = (in_time > TIME_MAX) ? TIME_MAX : in_time;

    cpu_fmt_bcd u_bcd (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (accept_s),
        .bin_i   (time_sat_s),
        .done_o  (bcd_done_s),
        .bcd_o   (bcd_s)
    );

    // Field lengths: significant timestamp digits and register-number split.
    always_comb begin
        if (bcd_s[15:12] != 4'd0) begin
            tlen_s = 6'd4;
        end else if (bcd_s[11:8] != 4'd0) begin
            tlen_s = 6'd3;
        end else if (bcd_s[7:4] != 4'd0) begin
            tlen_s = 6'd2;
        end else begin
            tlen_s = 6'd1;
        end

        if (reg_q >= 5'd30) begin
            reg_tens_s = 4'd3;
            reg_ones_s = 4'(reg_q - 5'd30);
        end else if (reg_q >= 5'd20) begin
            reg_tens_s = 4'd2;
            reg_ones_s = 4'(reg_q - 5'd20);
        end else if (reg_q >= 5'd10) begin
            reg_tens_s = 4'd1;
            reg_ones_s = 4'(reg_q - 5'd10);
        end else begin
            reg_tens_s = 4'd0;
            reg_ones_s = 4'(reg_q);
        end

        rlen_s = (reg_tens_s != 4'd0) ? 6'd2 : 6'd1;
        vlen_s = (kind_q == KIND_MEM) ? 6'd8 : rlen_s;
    end

    // Character at the next index; j, m, n are offsets past T, past the kind
    // symbol, and past the register/address field respectively.
    always_comb begin
        k_s = idx_q + 6'd1;
        j_s = k_s - 6'd1 - tlen_s;
        m_s = j_s - 6'd12;
        n_s = m_s - vlen_s;
        next_char_d = 8'h00;
        if (k_s <= tlen_s) begin
            next_char_d = hex_ascii(nib_of({16'h0000, bcd_s}, 3'(tlen_s - k_s)));
        end else if (j_s == 6'd0) begin
            next_char_d = ASC_AT;
        end else if (j_s <= 6'd8) begin
            next_char_d = hex_ascii(nib_of(pc_q, 3'(6'd8 - j_s)));
        end else if (j_s == 6'd9) begin
            next_char_d = ASC_COLON;
        end else if (j_s == 6'd10) begin
            next_char_d = ASC_SPACE;
        end else if (j_s == 6'd11) begin
            next_char_d = (kind_q == KIND_MEM) ? ASC_STAR : ASC_DOLLAR;
        end else if (m_s < vlen_s) begin
            if (kind_q == KIND_MEM) begin
                next_char_d = hex_ascii(nib_of(addr_q, 3'(6'd7 - m_s)));
            end else if ((rlen_s == 6'd2) && (m_s == 6'd0)) begin
                next_char_d = hex_ascii(reg_tens_s);
            end else begin
                next_char_d = hex_ascii(reg_ones_s);
            end
        end else begin
            case (n_s)
                6'd0:    next_char_d = ASC_SPACE;
                6'd1:    next_char_d = ASC_LT;
                6'd2:    next_char_d = ASC_EQ;
                6'd3:    next_char_d = ASC_SPACE;
                6'd12:   next_char_d = ASC_HASH;
                default: begin
                    if ((n_s >= 6'd4) && (n_s <= 6'd11)) begin
                        next_char_d = hex_ascii(nib_of(data_q, 3'(6'd11 - n_s)));
                    end else begin
                        next_char_d = 8'h00;
                    end
                end
            endcase
        end
    end

    // Frame FSM: latch record, wait for BCD, then stream characters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_REG;
            pc_q    <= 32'd0;
            reg_q   <= 5'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            idx_q   <= 6'd0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q <= ST_CONV;
                        kind_q  <= kind_e'(in_kind);
                        pc_q    <= in_pc;
                        reg_q   <= in_reg;
                        addr_q  <= in_addr;
                        data_q  <= in_data;
                        idx_q   <= 6'd0;
                    end
                end
                ST_CONV: begin
                    if (bcd_done_s) begin
                        state_q <= ST_EMIT;
                        idx_q   <= 6'd0;
                        char_q  <= ASC_CARET;
                        valid_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (valid_q && out_ready) begin
                        if (char_q == ASC_HASH) begin
                            state_q <= ST_IDLE;
                            idx_q   <= 6'd0;
                            char_q  <= 8'h00;
                            valid_q <= 1'b0;
                        end else begin
                            idx_q  <= k_s;
                            char_q <= next_char_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= 6'd0;
                    char_q  <= 8'h00;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_char   = char_q;
    assign out_valid  = valid_q;
    assign frame_done = valid_q && out_ready && (char_q == ASC_HASH);

endmodule

// File: tb/tb_cpu_formatter.sv
// Directed bench for cpu_formatter: hand-written expected trace lines,
// latency, stall, back-to-back and mid-frame reset scenarios.
module tb_cpu_formatter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_kind;
    logic [13:0] in_time;
    logic [31:0] in_pc;
    logic [4:0]  in_reg;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;

    int n_vec = 0;
    int n_bad = 0;

    cpu_formatter dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_reg     (in_reg),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .out_char   (out_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic send(input logic kind, input logic [13:0] t, input logic [31:0] pc,
                        input logic [4:0] rg, input logic [31:0] ad, input logic [31:0] dt);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_vec("send_ready", {31'd0, in_ready}, 32'd1);
        in_kind  = kind;
        in_time  = t;
        in_pc    = pc;
        in_reg   = rg;
        in_addr  = ad;
        in_data  = dt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_vec("accepted", {31'd0, in_ready}, 32'd0);
        in_kind  = 1'($urandom_range(0, 1));
        in_time  = 14'($urandom);
        in_pc    = $urandom;
        in_reg   = 5'($urandom);
        in_addr  = $urandom;
        in_data  = $urandom;
    endtask

    // Collect a frame (or its first 'limit' chars) and compare against exp.
    task automatic collect(input string exp, input int limit, input bit rnd);
        int   lat;
        int   taken;
        int   target;
        bit   first;
        bit   stalled;
        bit   fin;
        logic [7:0] held;
        lat = 0; taken = 0; first = 0; stalled = 0; fin = 0; held = 8'h00;
        target = (limit != 0) ? limit : exp.len();
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(posedge clk);
            if (!first) lat++;
            #1 out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!first && out_valid) begin
                first = 1;
                check_vec("latency", lat, 32'd14);
            end
            if (!out_valid) check_vec("char_when_invalid", {24'd0, out_char}, 32'd0);
            if (stalled) check_vec("stall_hold", {24'd0, out_char}, {24'd0, held});
            stalled = out_valid && !out_ready;
            held    = out_char;
            if (out_valid && out_ready) begin
                check_vec("char", {24'd0, out_char}, {24'd0, exp[taken]});
                check_vec("frame_done", {31'd0, frame_done},
                          {31'd0, (taken == exp.len() - 1)});
                taken++;
                if (taken == target) begin
                    @(posedge clk);
                    fin = 1;
                end
            end else if (out_valid) begin
                check_vec("frame_done_stall", {31'd0, frame_done}, 32'd0);
            end
        end
        if (!fin) check_vec("collect_timeout", taken, target);
        if (limit == 0) begin
            #1;
            check_vec("idle_after_frame", {30'd0, in_ready, out_valid}, 32'd2);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_kind   = 1'b0;
        in_time   = 14'd0;
        in_pc     = 32'd0;
        in_reg    = 5'd0;
        in_addr   = 32'd0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #1;
        check_vec("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_vec("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_vec("rst_out_char", {24'd0, out_char}, 32'd0);
        check_vec("rst_frame_done", {31'd0, frame_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        send(1'b0, 14'd5, 32'h00003000, 5'd31, 32'h0, 32'h12345678);
        collect("^5@00003000: $31 <= 12345678#", 0, 1'b0);

        send(1'b1, 14'd1234, 32'h00003004, 5'd0, 32'h00000000, 32'hffffffff);
        collect("^1234@00003004: *00000000 <= ffffffff#", 0, 1'b0);

        send(1'b0, 14'd0, 32'h00000000, 5'd0, 32'h0, 32'h00000000);
        collect("^0@00000000: $0 <= 00000000#", 0, 1'b0);

        send(1'b1, 14'd16383, 32'hdeadbeef, 5'd0, 32'h0000abcd, 32'h0badf00d);
        collect("^9999@deadbeef: *0000abcd <= 0badf00d#", 0, 1'b0);

        send(1'b0, 14'd100, 32'h00001234, 5'd10, 32'h0, 32'h00c0ffee);
        collect("^100@00001234: $10 <= 00c0ffee#", 0, 1'b1);

        send(1'b0, 14'd9999, 32'h89abcdef, 5'd9, 32'h0, 32'ha5a5a5a5);
        collect("^9999@89abcdef: $9 <= a5a5a5a5#", 0, 1'b1);

        // Back-to-back: second record is held valid during the first frame.
        send(1'b1, 14'd42, 32'h00000010, 5'd0, 32'h80000000, 32'h00000001);
        in_kind  = 1'b0;
        in_time  = 14'd10000;
        in_pc    = 32'hffff0000;
        in_reg   = 5'd7;
        in_addr  = 32'h0;
        in_data  = 32'h7fffffff;
        in_valid = 1'b1;
        collect("^42@00000010: *80000000 <= 00000001#", 0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_vec("b2b_accepted", {31'd0, in_ready}, 32'd0);
        collect("^9999@ffff0000: $7 <= 7fffffff#", 0, 1'b0);

        // Reset in the middle of a frame, then a fresh frame.
        send(1'b0, 14'd777, 32'h11111111, 5'd3, 32'h0, 32'h22222222);
        collect("^777@11111111: $3 <= 22222222#", 6, 1'b0);
        #3 reset = 1'b0;
        #1;
        check_vec("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_vec("midrst_out_char", {24'd0, out_char}, 32'd0);
        check_vec("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_vec("abandoned", {31'd0, out_valid}, 32'd0);
        end
        send(1'b1, 14'd9, 32'h00000abc, 5'd0, 32'h12345678, 32'h9abcdef0);
        collect("^9@00000abc: *12345678 <= 9abcdef0#", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_formatter.md
CPU_FORMATTER -- requirements
Module: cpu_formatter

Interface
REQ-001 clk  input  1  Single clock; all state changes on its rising edge.
REQ-002 reset  input  1  Asynchronous reset, active-low: 0 resets, 1 runs.
REQ-003 in_valid  input  1  A write record is offered on the in_* fields.
REQ-004 in_ready  output  1  Formatter can accept a record this cycle.
REQ-005 in_kind  input  1  0 = register write ("$" line), 1 = memory write ("*" line).
REQ-006 in_time  input  14  Timestamp, unsigned binary.
REQ-007 in_pc  input  32  PC, printed as hex.
REQ-008 in_reg  input  5  Register number, printed as decimal; used only when in_kind = 0.
REQ-009 in_addr  input  32  Memory address, printed as hex; used only when in_kind = 1.
REQ-010 in_data  input  32  Written data, printed as hex.
REQ-011 out_char  output  8  ASCII character being presented.
REQ-012 out_valid  output  1  out_char is valid.
REQ-013 out_ready  input  1  Sink takes out_char this cycle.
REQ-014 frame_done  output  1  One-cycle pulse in the cycle the final "#" is taken.

Function
REQ-015 A record SHALL be accepted on a rising edge where in_valid = 1 and in_ready = 1; all in_* fields are latched on that edge.
REQ-016 in_ready SHALL be 1 only in state IDLE.
REQ-017 States SHALL be IDLE -> CONV -> EMIT -> IDLE: IDLE to CONV on accept, CONV to EMIT after exactly 14 cycles, EMIT to IDLE when "#" is taken.
REQ-018 CONV SHALL convert the latched time to four BCD digits by iterative double-dabble, one bit per cycle.
REQ-019 A latched time above 9999 SHALL be saturated to 9999 before conversion.
REQ-020 out_valid SHALL first be 1 in the cycle after the 14th rising edge following the accepting edge.
REQ-021 Register-write frames SHALL be exactly: "^" T "@" P8 ":" " " "$" R " <= " D8 "#".
REQ-022 Memory-write frames SHALL be exactly: "^" T "@" P8 ":" " " "*" A8 " <= " D8 "#".
REQ-023 T SHALL be the time in decimal with no leading zeros, 1 to 4 digits; a value of 0 prints as "0".
REQ-024 R SHALL be the register number in decimal with no leading zeros, 1 to 2 digits.
REQ-025 P8, A8 and D8 SHALL each be exactly 8 lowercase hex digits, most significant nibble first, with leading zeros kept.
REQ-026 Frame length SHALL be 26 + len(T) + len(R) characters for register writes and 34 + len(T) for memory writes.
REQ-027 A character SHALL be taken on each edge where out_valid = 1 and out_ready = 1.
REQ-028 While out_valid = 1 and out_ready = 0, out_char SHALL hold its value and the frame SHALL not advance.
REQ-029 Characters SHALL be presented back-to-back with no idle cycle while out_ready = 1.
REQ-030 out_valid SHALL be 0 in IDLE and CONV.
REQ-031 frame_done SHALL be 1 only in the cycle the "#" is taken; IDLE is reached at the next edge.
REQ-032 A new record SHALL not be accepted in the same cycle that "#" is taken; the earliest acceptance is the following cycle.
REQ-033 in_* changes while not in IDLE SHALL have no effect on the frame in progress.
REQ-034 out_char SHALL be 8'h00 whenever out_valid = 0.

Reset
REQ-035 reset = 0 SHALL immediately force state IDLE and in_ready = 1, out_valid = 0, out_char = 8'h00, frame_done = 0.
REQ-036 The character index, BCD registers and all latched fields SHALL be cleared on reset.
REQ-037 Reset during CONV or EMIT SHALL abandon the frame; no further characters of it are emitted after release.
REQ-038 After reset release, the first rising edge with in_valid = 1 SHALL accept a record.

Structure
REQ-039 Package cpu_fmt_pkg SHALL hold the ASCII constants ("^", "@", ":", " ", "$", "*", "<", "=", "#"), the kind encoding, the state encoding and the 14-cycle CONV length.
REQ-040 The double-dabble SHALL be the sub-module cpu_fmt_bcd (start, 14-bit in, done, 16-bit BCD out).
REQ-041 Hex-nibble-to-ASCII conversion SHALL be a shared function.

Verification
REQ-042 kind 0, time 5, pc 0x00003000, reg 31, data 0x12345678, out_ready = 1 -> "^5@00003000: $31 <= 12345678#", 29 characters, frame_done on "#".
REQ-043 kind 1, time 1234, pc 0x00003004, addr 0, data 0xffffffff -> "^1234@00003004: *00000000 <= ffffffff#", 38 characters.
REQ-044 time 0 and reg 0 -> T = "0", R = "0"; time 16383 -> T = "9999".
REQ-045 out_ready toggled pseudo-randomly -> identical character sequence, out_char stable while stalled, no loss and no duplicates.
REQ-046 Two back-to-back records with in_valid held at 1 -> second accepted the cycle after frame_done; first character 14 clocks later.
REQ-047 reset asserted mid-EMIT, then a new record -> out_valid drops immediately and only the new frame appears, complete and intact.
